// File: rtl/channel_merge_arbiter_pkg.sv
// Shared definitions for the two-input dual-rail (e1of2) merge arbiter:
// FSM encoding, rail codes and the default synchronizer depth.
package channel_merge_arbiter_pkg;

  localparam int SYNC_STAGES_DEFAULT = 2;

  localparam logic [1:0] NEUTRAL = 2'b00;
  localparam logic [1:0] D0      = 2'b01;
  localparam logic [1:0] D1      = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND        = 2'd1,
    IN_NEUTRAL  = 2'd2,
    OUT_NEUTRAL = 2'd3
  } state_t;

  // A dual-rail word carries data only when exactly one rail is high.
  function automatic logic rail_valid(input logic [1:0] d);
    return (d == D0) || (d == D1);
  endfunction

endpackage

// File: rtl/channel_merge_arbiter_sync_flops.sv
// Multi-flop synchronizer for asynchronous handshake inputs; depth and
// width are parameters, all stages clear on synchronous reset.
module sync_flops #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] q_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) q_reg <= '0;
          else       q_reg <= d;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (reset) q_reg <= '0;
          else       q_reg <= g_stage[gi-1].q_reg;
        end
      end
    end
  endgenerate

  assign q = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/channel_merge_arbiter.sv
// Merges two four-phase e1of2 input channels onto one output channel with
// round-robin arbitration; every decision is made on synchronized inputs.
module channel_merge_arbiter
  import channel_merge_arbiter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       l0_d,
  output logic             l0_e,
  input  logic [1:0]       l1_d,
  output logic             l1_e,
  output logic [1:0]       r_d,
  input  logic             r_e,
  output logic             grant,
  output logic             busy,
  output logic [CNT_W-1:0] tokens,
  output logic             proto_err
);

  logic [1:0] l0_s;
  logic [1:0] l1_s;
  logic       r_e_s;

  sync_flops #(.DEPTH(SYNC_STAGES), .WIDTH(2)) u_sync_l0 (
    .clk(clk), .reset(reset), .d(l0_d), .q(l0_s)
  );
  sync_flops #(.DEPTH(SYNC_STAGES), .WIDTH(2)) u_sync_l1 (
    .clk(clk), .reset(reset), .d(l1_d), .q(l1_s)
  );
  sync_flops #(.DEPTH(SYNC_STAGES), .WIDTH(1)) u_sync_re (
    .clk(clk), .reset(reset), .d(r_e), .q(r_e_s)
  );

  state_t           state_reg;
  logic             rr_reg;
  logic             grant_reg;
  logic [1:0]       r_d_reg;
  logic             l0_e_reg;
  logic             l1_e_reg;
  logic [CNT_W-1:0] tokens_reg;
  logic             proto_err_reg;

  logic       v0;
  logic       v1;
  logic       sel_next;
  logic [1:0] sel_d;
  logic [1:0] granted_d;

  // Illegal (both-rails) words fail rail_valid, so they can never win.
  always_comb begin
    v0        = rail_valid(l0_s);
    v1        = rail_valid(l1_s);
    sel_next  = (v0 && v1) ? rr_reg : v1;
    sel_d     = sel_next ? l1_s : l0_s;
    granted_d = grant_reg ? l1_s : l0_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      rr_reg        <= 1'b0;
      grant_reg     <= 1'b0;
      r_d_reg       <= NEUTRAL;
      l0_e_reg      <= 1'b1;
      l1_e_reg      <= 1'b1;
      tokens_reg    <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      if ((l0_s == ILLEGAL) || (l1_s == ILLEGAL)) proto_err_reg <= 1'b1;
      unique case (state_reg)
        IDLE: begin
          if (r_e_s && (v0 || v1)) begin
            grant_reg <= sel_next;
            r_d_reg   <= sel_d;
            state_reg <= SEND;
          end
        end
        SEND: begin
          if (!r_e_s) begin
            if (grant_reg) l1_e_reg <= 1'b0;
            else           l0_e_reg <= 1'b0;
            state_reg <= IN_NEUTRAL;
          end
        end
        IN_NEUTRAL: begin
          if (granted_d == NEUTRAL) begin
            r_d_reg   <= NEUTRAL;
            state_reg <= OUT_NEUTRAL;
          end
        end
        OUT_NEUTRAL: begin
          if (r_e_s) begin
            l0_e_reg   <= 1'b1;
            l1_e_reg   <= 1'b1;
            rr_reg     <= ~grant_reg;
            tokens_reg <= tokens_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign l0_e      = l0_e_reg;
  assign l1_e      = l1_e_reg;
  assign r_d       = r_d_reg;
  assign grant     = grant_reg;
  assign busy      = (state_reg != IDLE);
  assign tokens    = tokens_reg;
  assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_channel_merge_arbiter.sv
// Self-checking bench: four-phase requesters and sink driven per cycle,
// results checked against per-requester expected-token queues.
module tb_channel_merge_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  l0_d, l1_d;
  logic        r_e;
  logic        l0_e, l1_e, grant, busy, proto_err;
  logic [1:0]  r_d;
  logic [15:0] tokens;
  logic        w_l0_e, w_l1_e, w_grant, w_busy, w_proto_err;
  logic [1:0]  w_r_d;
  logic [3:0]  w_tokens;

  always #5 clk = ~clk;

  channel_merge_arbiter #(.SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .l0_d(l0_d), .l0_e(l0_e), .l1_d(l1_d),
    .l1_e(l1_e), .r_d(r_d), .r_e(r_e), .grant(grant), .busy(busy),
    .tokens(tokens), .proto_err(proto_err)
  );

  // Narrow-counter copy on the same stimulus, used for the wrap check.
  channel_merge_arbiter #(.SYNC_STAGES(2), .CNT_W(4)) dut_wrap (
    .clk(clk), .reset(reset), .l0_d(l0_d), .l0_e(w_l0_e), .l1_d(l1_d),
    .l1_e(w_l1_e), .r_d(w_r_d), .r_e(r_e), .grant(w_grant), .busy(w_busy),
    .tokens(w_tokens), .proto_err(w_proto_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  bit pend0[$], pend1[$], exp0[$], exp1[$];
  int ghist[$];
  int dly0, dly1, sdly, req_max, sink_max, model_tokens;
  bit sink_hold, sink_freeze, man1, seen_l0_low, seen_l1_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rnd(input int mx);
    return (mx == 0) ? 0 : int'($urandom_range(mx, 0));
  endfunction

  task automatic record();
    bit b;
    ghist.push_back(int'(grant));
    model_tokens++;
    chk("busy_while_data", busy, 1);
    if (grant == 1'b0) begin
      chk("exp0_nonempty", exp0.size() > 0, 1);
      if (exp0.size() > 0) begin
        b = exp0.pop_front();
        chk("r_d_from_l0", r_d, b ? 2 : 1);
      end
    end else begin
      chk("exp1_nonempty", exp1.size() > 0, 1);
      if (exp1.size() > 0) begin
        b = exp1.pop_front();
        chk("r_d_from_l1", r_d, b ? 2 : 1);
      end
    end
  endtask

  // One environment cycle: requesters and sink react to the DUT outputs.
  task automatic step();
    bit b;
    @(negedge clk);
    if (!l0_e) begin seen_l0_low = 1; chk("l0_e_low_owner", {busy, grant}, 2'b10); end
    if (!l1_e) begin seen_l1_low = 1; chk("l1_e_low_owner", {busy, grant}, 2'b11); end
    if (l0_d != 2'b00) begin
      if (!l0_e) begin l0_d = 2'b00; dly0 = rnd(req_max); end
    end else if (l0_e && pend0.size() > 0) begin
      if (dly0 > 0) dly0--;
      else begin b = pend0.pop_front(); exp0.push_back(b); l0_d = b ? 2'b10 : 2'b01; end
    end
    if (!man1) begin
      if (l1_d != 2'b00) begin
        if (!l1_e) begin l1_d = 2'b00; dly1 = rnd(req_max); end
      end else if (l1_e && pend1.size() > 0) begin
        if (dly1 > 0) dly1--;
        else begin b = pend1.pop_front(); exp1.push_back(b); l1_d = b ? 2'b10 : 2'b01; end
      end
    end
    if (!sink_freeze) begin
      if (sink_hold) r_e = 1'b0;
      else if (r_e && (r_d == 2'b01 || r_d == 2'b10)) begin
        if (sdly > 0) sdly--;
        else begin record(); r_e = 1'b0; sdly = rnd(sink_max); end
      end else if (!r_e && r_d == 2'b00) begin
        if (sdly > 0) sdly--;
        else begin r_e = 1'b1; sdly = rnd(sink_max); end
      end
    end
  endtask

  task automatic env_reset();
    @(negedge clk);
    reset = 1'b1; l0_d = 2'b00; l1_d = 2'b00; r_e = 1'b1;
    pend0.delete(); pend1.delete(); exp0.delete(); exp1.delete(); ghist.delete();
    dly0 = 0; dly1 = 0; sdly = 0; req_max = 0; sink_max = 0; model_tokens = 0;
    sink_hold = 0; sink_freeze = 0; man1 = 0; seen_l0_low = 0; seen_l1_low = 0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic bit quiet();
    return pend0.size() == 0 && pend1.size() == 0 && exp0.size() == 0 &&
           exp1.size() == 0 && l0_d == 2'b00 && l1_d == 2'b00 && r_e && !busy;
  endfunction

  task automatic wait_done(input int budget, input string tag);
    int stable = 0;
    for (int c = 0; c < budget && stable < 8; c++) begin
      step();
      if (quiet()) stable++; else stable = 0;
    end
    chk({tag, "_done"}, stable >= 8, 1);
    chk({tag, "_wrap_idle"}, {w_busy, w_l0_e, w_l1_e, w_r_d}, 5'b01100);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; l0_d = 2'b00; l1_d = 2'b00; r_e = 1'b1;

    // Reset state
    env_reset();
    chk("rst_l0_e", l0_e, 1);
    chk("rst_l1_e", l1_e, 1);
    chk("rst_r_d", r_d, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tokens", tokens, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_wrap_state", {w_grant, w_proto_err, w_tokens}, 0);

    // Single token from requester 0
    pend0.push_back(1'b1);
    wait_done(300, "single");
    chk("single_count", ghist.size(), 1);
    chk("single_grant", ghist[0], 0);
    chk("single_l0_e_dropped", seen_l0_low, 1);
    chk("single_l1_e_held", seen_l1_low, 0);
    chk("single_tokens", tokens, 1);

    // Contention: both valid in the same cycle, rr starts at 0
    env_reset();
    pend0.push_back(1'b0);
    pend1.push_back(1'b1);
    wait_done(400, "contend");
    chk("contend_count", ghist.size(), 2);
    chk("contend_first", ghist[0], 0);
    chk("contend_second", ghist[1], 1);
    chk("contend_tokens", tokens, 2);

    // Fairness: two continuous streams of 8 tokens each
    env_reset();
    for (int k = 0; k < 8; k++) begin
      pend0.push_back(1'($urandom));
      pend1.push_back(1'($urandom));
    end
    wait_done(3000, "fair");
    chk("fair_count", ghist.size(), 16);
    for (int k = 0; k < 16 && k < ghist.size(); k++) chk("fair_grant", ghist[k], k % 2);
    chk("fair_tokens", tokens, 16);

    // Counter wrap: 17 transfers on a 4-bit counter
    env_reset();
    for (int k = 0; k < 9; k++) pend0.push_back(1'($urandom));
    for (int k = 0; k < 8; k++) pend1.push_back(1'($urandom));
    wait_done(3000, "wrap");
    chk("wrap_tokens_main", tokens, 17);
    chk("wrap_tokens_narrow", w_tokens, 1);

    // Backpressure: sink not ready, nothing may be granted
    env_reset();
    sink_hold = 1;
    pend0.push_back(1'b0);
    for (int k = 0; k < 40; k++) begin
      step();
      if (k % 10 == 9) begin
        chk("bp_busy", busy, 0);
        chk("bp_r_d", r_d, 0);
      end
    end
    sink_hold = 0;
    wait_done(300, "bp");
    chk("bp_tokens", tokens, 1);
    chk("bp_grant", ghist[0], 0);

    // Illegal input on requester 1
    env_reset();
    man1 = 1;
    l1_d = 2'b11;
    repeat (10) step();
    chk("illegal_proto_err", proto_err, 1);
    chk("illegal_wrap_proto_err", w_proto_err, 1);
    chk("illegal_no_grant", busy, 0);
    l1_d = 2'b00;
    pend0.push_back(1'b0);
    wait_done(300, "illegal");
    chk("illegal_count", ghist.size(), 1);
    chk("illegal_sticky", proto_err, 1);

    // Reset during SEND abandons the transfer
    env_reset();
    sink_freeze = 1;
    pend0.push_back(1'b1);
    begin
      int c = 0;
      while (c < 60 && !(busy && r_d != 2'b00)) begin step(); c++; end
      chk("mid_send_reached", busy && r_d == 2'b10, 1);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk) #1;
    chk("mid_rst_r_d", r_d, 0);
    chk("mid_rst_enables", {l0_e, l1_e}, 2'b11);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tokens", tokens, 0);

    // Randomized traffic with random requester and sink delays
    env_reset();
    req_max = 6;
    sink_max = 5;
    for (int round = 0; round < 3; round++) begin
      int n0 = int'($urandom_range(12, 4));
      int n1 = int'($urandom_range(12, 4));
      for (int k = 0; k < n0; k++) pend0.push_back(1'($urandom));
      for (int k = 0; k < n1; k++) pend1.push_back(1'($urandom));
      wait_done(20000, "rand");
      chk("rand_tokens", tokens, model_tokens);
      chk("rand_wrap_tokens", w_tokens, model_tokens % 16);
    end
    chk("rand_hist", ghist.size(), model_tokens);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/channel_merge_arbiter.md
CHANNEL_MERGE_ARBITER -- requirements
Module: channel_merge_arbiter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets flop depth of every input synchronizer (legal range 1..4).
REQ-002 Parameter CNT_W, default 16, sets width of the token counter.
REQ-003 Ports, one clock; reset is synchronous and active-high: clk (input, 1, sole clock, rising edge); reset (input, 1, synchronous active-high reset).
REQ-004 l0_d  input  2  dual-rail data from requester 0 ([0]=false rail, [1]=true rail), asynchronous to clk.
REQ-005 l0_e  output 1  enable (acknowledge, active-high = ready) to requester 0.
REQ-006 l1_d  input  2  dual-rail data from requester 1, asynchronous to clk.
REQ-007 l1_e  output 1  enable to requester 1.
REQ-008 r_d   output 2  dual-rail data to shared output channel.
REQ-009 r_e   input  1  enable from output sink, asynchronous to clk.
REQ-010 grant output 1  index of requester currently owning the output channel, valid when busy=1.
REQ-011 busy  output 1  high in any state other than IDLE.
REQ-012 tokens output CNT_W  count of completed transfers.
REQ-013 proto_err output 1  sticky flag: an input showed both rails high.

Function
REQ-014 All channels SHALL use four-phase e1of2 handshake: data valid = exactly one rail high; neutral = both rails low.
REQ-015 l0_d, l1_d, r_e SHALL each pass through a SYNC_STAGES-flop synchronizer; all decisions use synchronized values only.
REQ-016 FSM states SHALL be IDLE, SEND, IN_NEUTRAL, OUT_NEUTRAL.
REQ-017 IDLE: when >=1 synchronized input is valid and synchronized r_e=1, SHALL select requester, latch its data bit, go to SEND next cycle.
REQ-018 Both inputs valid in same cycle: SHALL grant requester indicated by round-robin pointer rr; rr resets to 0.
REQ-019 SEND: r_d SHALL drive one-hot latched bit (01 for 0, 10 for 1) from the first SEND cycle; hold until synchronized r_e=0.
REQ-020 On r_e=0 in SEND: SHALL deassert granted l*_e, go to IN_NEUTRAL; r_d held.
REQ-021 IN_NEUTRAL: when granted input synchronized neutral, SHALL drive r_d=00, go to OUT_NEUTRAL.
REQ-022 OUT_NEUTRAL: when synchronized r_e=1, SHALL reassert granted l*_e, set rr to other requester, increment tokens (wraps modulo 2^CNT_W), go to IDLE.
REQ-023 Non-granted l*_e SHALL stay 1 throughout; its pending data SHALL wait, not be dropped.
REQ-024 Input with both rails high SHALL set proto_err and is treated as not valid; never granted while illegal.
REQ-025 IDLE with r_e=0: SHALL not grant; wait.
REQ-026 Minimum transfer: 4 FSM cycles plus synchronizer latency per edge; no combinational path input->output.

Reset
REQ-027 Reset SHALL force: state IDLE, l0_e=1, l1_e=1, r_d=00, grant=0, busy=0, rr=0, tokens=0, proto_err=0, synchronizers cleared to 0.
REQ-028 Reset mid-transfer SHALL abandon transfer immediately (r_d=00 next edge) with no counter increment; reset dominates all other conditions.

Structure
REQ-029 Shared package SHALL hold state encoding enum, dual-rail constants (NEUTRAL=2'b00, D0=2'b01, D1=2'b10), and SYNC_STAGES default.
REQ-030 Synchronizer SHALL be one sub-module, sync_flops, parameterized by depth and width, instanced once per asynchronous input group.
REQ-031 Registers in this block SHALL all be on clk, synchronous reset.

Verification
REQ-032 Single token: reset, r_e=1, l0_d=10 -> r_d=10, grant=0; sink r_e=0 -> l0_e=0; l0_d=00 -> r_d=00; r_e=1 -> l0_e=1, tokens=1.
REQ-033 Contention: l0_d=01 and l1_d=10 same cycle after reset -> first r_d=01 (grant 0), second r_d=10 (grant 1), tokens=2, l1_e stays 1 during first transfer.
REQ-034 Fairness: both requesters stream 8 tokens continuously -> grants strictly alternate 0,1,0,1..., tokens=16.
REQ-035 Backpressure: r_e held 0 with l0_d valid -> busy=0, r_d=00 indefinitely; r_e=1 -> transfer proceeds.
REQ-036 Illegal/reset: l1_d=11 -> proto_err=1, no grant; reset asserted during SEND -> r_d=00, l0_e=l1_e=1, tokens unchanged.
REQ-037 Wrap: CNT_W=4, 17 transfers -> tokens=1.
